aes_block_axi_master: RTL and testbench
=======================================

Name: aes_block_axi_master

Overview:
- AXI4-Lite master that moves 128-bit AES blocks between the AES datapath and axi_sram_512x45_wrapper, as four 32-bit single-beat transfers.
- Sits directly upstream of the SRAM wrapper's AXI slave port; the AES core or controller drives its command/response side.
- One block command is in flight at a time: read (load plaintext/key) or write (store ciphertext).

Parameters:
ADDR_W, 32, AXI byte-address width
BEATS, 4, words per block; fixed at 4, no other value supported

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = store block, 0 = load block
cmd_addr  in  ADDR_W  block byte address; must be 16-byte aligned
cmd_wdata  in  128  block to store; word k = bits [32k+31:32k]
rsp_valid  out  1  command completed
rsp_ready  in  1  response accepted
rsp_rdata  out  128  loaded block, same word order; 0 for writes
rsp_err  out  1  misaligned address or any non-OKAY AXI response
axi_awaddr/awvalid/awready, axi_wdata/wstrb/wvalid/wready, axi_bresp/bvalid/bready, axi_araddr/arvalid/arready, axi_rdata/rresp/rvalid/rready: standard AXI4-Lite master ports; address ADDR_W, data 32, strobe 4, resp 2

Behaviour:
- Reset (async assert): state IDLE; cmd_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; all AXI valid and ready outputs 0; address/data outputs 0. Release is sampled at the next aclk edge.
- States: IDLE, WR_XFER, WR_RESP, RD_ADDR, RD_DATA, RESP.
- cmd_ready=1 only in IDLE.
- On accept, the block latches cmd_addr, cmd_wdata and cmd_write, and clears the beat counter (2 bits) and the error flag.
- Misaligned cmd_addr (cmd_addr[3:0]!=0): go straight to RESP with rsp_err=1. No AXI traffic.
- WR_XFER:
  - Entered the cycle after accept: awvalid=1 and wvalid=1 together; awaddr=base+4*beat; wdata=word[beat]; wstrb=4'hF.
  - Each valid drops independently on its own handshake (awready or wready). Either order and simultaneous handshakes are legal.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: bready=1 until bvalid.
  - bresp!=2'b00: set error, go to RESP. Remaining beats are not issued.
  - Otherwise, if beat==3, go to RESP; else beat++ and return to WR_XFER.
- RD_ADDR: arvalid=1, araddr=base+4*beat. On arready go to RD_DATA.
- RD_DATA: rready=1.
  - On rvalid, capture rdata into word[beat] of rsp_rdata.
  - rresp!=OKAY: set error and go to RESP. Words already captured are kept; the rest stay 0.
  - Otherwise, if beat==3, go to RESP; else beat++ and go to RD_ADDR.
- Only one AXI transaction is outstanding at any time. No AW/AR issue overlaps a pending B/R.
- Valids never drop before their handshake. Address and data are stable while valid is high.
- RESP: rsp_valid=1; rsp_rdata/rsp_err stable until rsp_ready, then IDLE next cycle. A new command is accepted at the earliest one cycle after the response handshake.
- rsp_rdata is cleared on command accept. On writes it stays 0.
- Latency with zero-wait slave (ready=1, response the cycle after address handshake):
  - write: accept→first awvalid 1 cycle; 2 cycles per beat; rsp_valid 9 cycles after accept.
  - read: same, 9 cycles.
- Address arithmetic is mod 2^ADDR_W. An aligned base cannot overflow within a block.
- Assertion of areset mid-transfer aborts immediately. Valids drop asynchronously and the block returns to IDLE; the partial transfer is not resumed.

Test Plan:
- Write cmd addr 0x100, wdata 0x00112233_44556677_8899AABB_DEADBEEF → AW at 0x100/0x104/0x108/0x10C with data DEADBEEF, 8899AABB, 44556677, 00112233, wstrb F; rsp_valid after 9 cycles, rsp_err=0.
- Read cmd addr 0x100 after that write → rsp_rdata equals the written 128-bit value, rsp_err=0, four AR beats in ascending order.
- Cmd addr 0x104 (misaligned), read and write → rsp_err=1 two cycles after accept; awvalid/arvalid never asserted.
- Slave holds awready low 3 cycles while wready=1 → wvalid drops after its handshake, awvalid held with stable awaddr until awready; block completes correctly.
- Slave returns bresp=SLVERR on beat 1 → rsp_err=1, no AW for 0x108/0x10C. On a read with rresp=SLVERR on beat 2 → rsp_rdata[95:64]=0, words 0–1 kept.
- rsp_ready held low 5 cycles → rsp_valid/rsp_rdata stable and cmd_ready=0 throughout. Then areset asserted mid-read (RD_DATA) → arvalid/rready/rsp_valid 0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/aes_block_axi_master.sv
// AXI4-Lite master moving one 128-bit AES block as four 32-bit single-beat transfers.
// One command and one AXI transaction in flight at a time.
module aes_block_axi_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BEATS  = 4
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [127:0]      cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [127:0]      rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [31:0]       axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [31:0]       axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_XFER,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [ADDR_W-5:0]   r_base_hi;
    logic [127:0]        r_blk;
    logic [1:0]          r_beat;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [127:0]        r_rsp_rdata;
    logic                r_rsp_err;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_awvalid;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_wvalid;
    logic                r_bready;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_arvalid;
    logic                r_rready;

    logic [1:0]          w_next_beat;
    logic [ADDR_W-1:0]   w_next_addr;
    logic [31:0]         w_next_word;
    logic                w_aw_fin;
    logic                w_w_fin;
    logic                w_misaligned;

    assign w_next_beat  = r_beat + 2'd1;
    assign w_next_addr  = {r_base_hi, w_next_beat, 2'b00};
    assign w_next_word  = r_blk[{w_next_beat, 5'd0} +: 32];
    // A channel whose valid has already dropped has completed its handshake.
    assign w_aw_fin     = !r_awvalid || axi_awready;
    assign w_w_fin      = !r_wvalid || axi_wready;
    assign w_misaligned = (cmd_addr[3:0] != 4'd0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_base_hi   <= '0;
            r_blk       <= '0;
            r_beat      <= '0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_base_hi   <= cmd_addr[ADDR_W-1:4];
                        r_blk       <= cmd_wdata;
                        r_beat      <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        if (w_misaligned) begin
                            r_rsp_err <= 1'b1;
                            r_state   <= S_RESP;
                        end else if (cmd_write) begin
                            r_awaddr  <= cmd_addr;
                            r_awvalid <= 1'b1;
                            r_wdata   <= cmd_wdata[31:0];
                            r_wstrb   <= '1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_XFER;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end

                S_WR_XFER: begin
                    if (axi_awready) r_awvalid <= 1'b0;
                    if (axi_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (axi_bresp != 2'b00) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (r_beat == LAST_BEAT) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_beat    <= w_next_beat;
                            r_awaddr  <= w_next_addr;
                            r_wdata   <= w_next_word;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR_XFER;
                        end
                    end
                end

                S_RD_ADDR: begin
                    if (axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_rsp_rdata[{r_beat, 5'd0} +: 32] <= axi_rdata;
                        if (axi_rresp != 2'b00) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (r_beat == LAST_BEAT) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_beat    <= w_next_beat;
                            r_araddr  <= w_next_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD_ADDR;
                        end
                    end
                end

                S_RESP: begin
                    // Misaligned commands arrive here with rsp_valid low and raise it one cycle later.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign axi_awaddr  = r_awaddr;
    assign axi_awvalid = r_awvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_wvalid  = r_wvalid;
    assign axi_bready  = r_bready;
    assign axi_araddr  = r_araddr;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = r_rready;

endmodule

// File: tb/tb_aes_block_axi_master.sv
// Bench for aes_block_axi_master: behavioural AXI4-Lite slave with wait/error injection,
// block-level reference memory, directed cases followed by randomized commands.
module tb_aes_block_axi_master;

    localparam int unsigned ADDR_W = 32;

    logic              aclk = 1'b0;
    logic              areset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [127:0]      cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [127:0]      rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [31:0]       axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic              axi_rready;

    always #5 aclk = ~aclk;

    aes_block_axi_master #(.ADDR_W(ADDR_W), .BEATS(4)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration (set by the stimulus side before each command).
    int unsigned cfg_aw_wait = 0, cfg_w_wait = 0, cfg_ar_wait = 0, cfg_resp_wait = 0;
    int unsigned cfg_err_beat = 4;
    int unsigned s_beat = 0;
    int unsigned proto_err = 0;

    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  strb_log[$];
    logic [31:0] ar_log[$];

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // Slave: all decisions made on the falling edge; handshakes land on the following rising edge.
    initial begin : slave
        bit aw_got, w_got, ar_got, b_pend, r_pend, aw_hold, w_hold, ar_hold;
        int unsigned aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        logic [31:0] aw_prev, w_prev, ar_prev, aw_cap, w_cap, ar_cap;
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_bvalid = 0; axi_bresp = 0; axi_rvalid = 0; axi_rresp = 0; axi_rdata = 0;
        {aw_got, w_got, ar_got, b_pend, r_pend, aw_hold, w_hold, ar_hold} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        {aw_prev, w_prev, ar_prev, aw_cap, w_cap, ar_cap} = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                axi_awready = 0; axi_wready = 0; axi_arready = 0;
                axi_bvalid = 0; axi_bresp = 0; axi_rvalid = 0; axi_rresp = 0; axi_rdata = 0;
                {aw_got, w_got, ar_got, b_pend, r_pend, aw_hold, w_hold, ar_hold} = '0;
                {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
            end else begin
                if ((axi_awvalid || axi_arvalid) && (b_pend || r_pend)) proto_err++;
                if ((axi_awvalid && aw_got) || (axi_wvalid && w_got) || (axi_arvalid && ar_got)) proto_err++;

                axi_bvalid = 0;
                if (b_pend) begin
                    if (b_cnt >= cfg_resp_wait) begin
                        axi_bvalid = 1;
                        axi_bresp  = (s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                        if (axi_bready) begin
                            if (axi_bresp == 2'b00) mem[aw_cap] = w_cap;
                            s_beat++; b_pend = 0; aw_got = 0; w_got = 0;
                        end
                    end else b_cnt++;
                end

                axi_rvalid = 0;
                if (r_pend) begin
                    if (r_cnt >= cfg_resp_wait) begin
                        axi_rvalid = 1;
                        axi_rresp  = (s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                        axi_rdata  = (axi_rresp != 2'b00) ? 32'h0 :
                                     (mem.exists(ar_cap) ? mem[ar_cap] : mem_default(ar_cap));
                        if (axi_rready) begin
                            s_beat++; r_pend = 0; ar_got = 0;
                        end
                    end else r_cnt++;
                end

                axi_awready = 0;
                if (axi_awvalid && !aw_got) begin
                    if (aw_hold && axi_awaddr !== aw_prev) proto_err++;
                    if (aw_cnt >= cfg_aw_wait) begin
                        axi_awready = 1; aw_got = 1; aw_cap = axi_awaddr;
                        aw_log.push_back(axi_awaddr); aw_hold = 0; aw_cnt = 0;
                    end else begin
                        aw_cnt++; aw_hold = 1; aw_prev = axi_awaddr;
                    end
                end else begin
                    if (aw_hold && !axi_awvalid) proto_err++;
                    aw_hold = 0;
                end

                axi_wready = 0;
                if (axi_wvalid && !w_got) begin
                    if (w_hold && axi_wdata !== w_prev) proto_err++;
                    if (w_cnt >= cfg_w_wait) begin
                        axi_wready = 1; w_got = 1; w_cap = axi_wdata;
                        w_log.push_back(axi_wdata); strb_log.push_back(axi_wstrb);
                        w_hold = 0; w_cnt = 0;
                    end else begin
                        w_cnt++; w_hold = 1; w_prev = axi_wdata;
                    end
                end else begin
                    if (w_hold && !axi_wvalid) proto_err++;
                    w_hold = 0;
                end

                axi_arready = 0;
                if (axi_arvalid && !ar_got) begin
                    if (ar_hold && axi_araddr !== ar_prev) proto_err++;
                    if (ar_cnt >= cfg_ar_wait) begin
                        axi_arready = 1; ar_got = 1; ar_cap = axi_araddr;
                        ar_log.push_back(axi_araddr); ar_hold = 0; ar_cnt = 0;
                        r_pend = 1; r_cnt = 0;
                    end else begin
                        ar_cnt++; ar_hold = 1; ar_prev = axi_araddr;
                    end
                end else begin
                    if (ar_hold && !axi_arvalid) proto_err++;
                    ar_hold = 0;
                end

                if (aw_got && w_got && !b_pend) begin
                    b_pend = 1; b_cnt = 0;
                end
            end
        end
    end

    task automatic pulse_reset();
        areset = 1;
        repeat (2) @(negedge aclk);
        #1 areset = 0;
    endtask

    task automatic set_waits(input int unsigned aw, input int unsigned w, input int unsigned ar,
                             input int unsigned rs);
        cfg_aw_wait = aw; cfg_w_wait = w; cfg_ar_wait = ar; cfg_resp_wait = rs;
    endtask

    // One block command end to end; the reference memory is updated from the command's own rules.
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [127:0] data,
                          input int unsigned errb, input int unsigned hold);
        int unsigned nb, lat, exp_lat, n;
        bit misal, exp_err, zero_wait;
        logic [127:0] exp_rd;
        misal     = (addr[3:0] != 4'd0);
        nb        = misal ? 0 : ((errb < 4) ? errb + 1 : 4);
        exp_err   = misal || (errb < 4);
        exp_lat   = misal ? 2 : 1 + 2 * nb;
        zero_wait = (cfg_aw_wait == 0) && (cfg_w_wait == 0) && (cfg_ar_wait == 0) && (cfg_resp_wait == 0);
        exp_rd    = '0;
        for (int k = 0; k < int'(nb); k++) begin
            if (k != int'(errb)) begin
                if (wr) ref_mem[addr + 32'(4 * k)] = data[32 * k +: 32];
                else    exp_rd[32 * k +: 32] = ref_word(addr + 32'(4 * k));
            end
        end
        if (wr) exp_rd = '0;

        aw_log.delete(); w_log.delete(); strb_log.delete(); ar_log.delete();
        s_beat = 0; cfg_err_beat = errb; proto_err = 0;

        @(negedge aclk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        if (!cmd_ready) begin
            cmd_valid = 0;
            pulse_reset();
            return;
        end
        @(negedge aclk);
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            @(negedge aclk);
            lat++;
        end
        check("rsp_timeout", rsp_valid, 1'b1);
        if (!rsp_valid) begin
            pulse_reset();
            return;
        end
        if (zero_wait) check("latency", lat, exp_lat);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("busy_cmd_ready", cmd_ready, 1'b0);
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge aclk);
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_rdata", rsp_rdata, exp_rd);
            check("hold_err", rsp_err, exp_err);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
        check("rsp_drop", rsp_valid, 1'b0);
        check("idle_cmd_ready", cmd_ready, 1'b1);

        check("aw_count", aw_log.size(), wr ? nb : 0);
        check("w_count", w_log.size(), wr ? nb : 0);
        check("ar_count", ar_log.size(), wr ? 0 : nb);
        for (int k = 0; k < aw_log.size() && k < int'(nb); k++)
            check("awaddr", aw_log[k], addr + 32'(4 * k));
        for (int k = 0; k < w_log.size() && k < int'(nb); k++) begin
            check("wdata", w_log[k], data[32 * k +: 32]);
            check("wstrb", strb_log[k], 4'hF);
        end
        for (int k = 0; k < ar_log.size() && k < int'(nb); k++)
            check("araddr", ar_log[k], addr + 32'(4 * k));
        check("protocol", proto_err, 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        n_mis++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned n;
        logic [31:0] addr;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        @(negedge aclk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_flags", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, rsp_valid, rsp_err}, 7'd0);
        check("rst_rdata", rsp_rdata, 128'd0);
        check("rst_addr_data", {axi_awaddr, axi_araddr, axi_wdata}, 96'd0);
        @(negedge aclk);
        #1 areset = 0;

        set_waits(0, 0, 0, 0);
        do_cmd(1, 32'h100, 128'h00112233_44556677_8899AABB_DEADBEEF, 4, 0);
        do_cmd(0, 32'h100, 128'h0, 4, 0);
        do_cmd(0, 32'h104, 128'h0, 4, 0);
        do_cmd(1, 32'h104, 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0, 4, 0);

        set_waits(3, 0, 0, 0);
        do_cmd(1, 32'h180, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 4, 0);
        set_waits(0, 0, 0, 0);
        do_cmd(0, 32'h180, 128'h0, 4, 0);

        do_cmd(1, 32'h200, 128'h11111111_22222222_33333333_44444444, 1, 0);
        do_cmd(0, 32'h100, 128'h0, 2, 0);
        do_cmd(0, 32'h100, 128'h0, 4, 5);

        // Abort a read while it waits in the data phase.
        set_waits(0, 0, 0, 6);
        cfg_err_beat = 4; s_beat = 0;
        @(negedge aclk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h100; cmd_wdata = '0;
        @(negedge aclk);
        cmd_valid = 0;
        n = 0;
        while (!axi_rready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("reach_rd_data", axi_rready, 1'b1);
        #2 areset = 1;
        #1;
        check("abort_arvalid", axi_arvalid, 1'b0);
        check("abort_rready", axi_rready, 1'b0);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        @(negedge aclk);
        #1 areset = 0;
        @(negedge aclk);
        check("post_abort_cmd_ready", cmd_ready, 1'b1);
        check("post_abort_rsp_valid", rsp_valid, 1'b0);
        set_waits(0, 0, 0, 0);
        do_cmd(0, 32'h100, 128'h0, 4, 0);

        for (int it = 0; it < 50; it++) begin
            if ($urandom_range(0, 9) == 0) addr = 32'hFFFF_FFF0;
            else addr = 32'h1000 + 32'($urandom_range(0, 15)) * 32'd16;
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) set_waits(0, 0, 0, 0);
            else set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            do_cmd(1'($urandom_range(0, 1)), addr, {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
